// File: rtl/core_run_monitor.sv
// Run-control/trace monitor: detects ECALL/EBREAK and watchdog expiry, counts cycles/instructions, drains, then halts. Trace buffer only with MON_TRACE_EN.
// Latency: counters and cause update one cycle after the qualifying edge; halt_o rises DRAIN_CYCLES+1 cycles after the stop edge; trace read data is registered (1 cycle).
// Backpressure: none; this block only observes the instruction stream and never stalls the core.
module core_run_monitor #(
    parameter int XLEN         = 32,
    parameter int CNT_W        = 32,
    parameter int TRACE_DEPTH  = 16,
    parameter int TIMEOUT      = 1000,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic [XLEN-1:0]              instr_i,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx_i,
    output logic                         halt_o,
    output logic [1:0]                   halt_cause_o,
    output logic [CNT_W-1:0]             cycle_cnt_o,
    output logic [CNT_W-1:0]             instr_cnt_o,
    output logic [$clog2(TRACE_DEPTH):0] trace_count_o,
    output logic [XLEN-1:0]              trace_pc_o,
    output logic [XLEN-1:0]              trace_instr_o
);
    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam logic [XLEN-1:0]  INSTR_ECALL  = XLEN'(32'h0000_0073);
    localparam logic [XLEN-1:0]  INSTR_EBREAK = XLEN'(32'h0010_0073);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [7:0]       DRAIN_LOAD   = 8'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       drain_q, drain_d;
    logic [CNT_W-1:0] cycle_q, instr_q;
    logic             accept;
    logic             stop_ecall, stop_ebreak, timeout_hit;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        drain_d     = drain_q;
        accept      = (state_q == ST_RUN) && valid_i;
        stop_ecall  = accept && (instr_i == INSTR_ECALL);
        stop_ebreak = accept && (instr_i == INSTR_EBREAK);
        timeout_hit = (TIMEOUT != 0) && (state_q == ST_RUN) && (cycle_q == TIMEOUT_LAST);

        case (state_q)
            ST_RUN: begin
                if (stop_ecall || stop_ebreak || timeout_hit) begin
                    // Instruction causes take precedence over a coincident timeout.
                    if (stop_ecall)       cause_d = 2'b01;
                    else if (stop_ebreak) cause_d = 2'b10;
                    else                  cause_d = 2'b11;
                    drain_d = DRAIN_LOAD;
                    state_d = (DRAIN_LOAD == 8'd0) ? ST_HALTED : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q <= 8'd1) state_d = ST_HALTED;
                else                 drain_d = drain_q - 8'd1;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cause_q <= 2'b00;
            drain_q <= 8'd0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            drain_q <= drain_d;
            if ((state_q != ST_HALTED) && (cycle_q != CNT_MAX)) cycle_q <= cycle_q + CNT_W'(1);
            if (accept && (instr_q != CNT_MAX))                 instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign halt_o       = (state_q == ST_HALTED);
    assign halt_cause_o = cause_q;
    assign cycle_cnt_o  = cycle_q;
    assign instr_cnt_o  = instr_q;

`ifdef MON_TRACE_EN
    logic [XLEN-1:0]  mem_pc    [TRACE_DEPTH];
    logic [XLEN-1:0]  mem_instr [TRACE_DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   tcount;
    logic [XLEN-1:0]  rd_pc, rd_instr;
    logic [IDX_W-1:0] rd_addr;

    // Index 0 is the most recent write, i.e. the slot just behind wr_ptr.
    assign rd_addr = wr_ptr - IDX_W'(1) - trace_rd_idx_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            tcount   <= '0;
            rd_pc    <= '0;
            rd_instr <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else begin
            rd_pc    <= mem_pc[rd_addr];
            rd_instr <= mem_instr[rd_addr];
            if (accept) begin
                mem_pc[wr_ptr]    <= pc_i;
                mem_instr[wr_ptr] <= instr_i;
                wr_ptr            <= wr_ptr + IDX_W'(1);
                if (tcount != (IDX_W+1)'(TRACE_DEPTH)) tcount <= tcount + (IDX_W+1)'(1);
            end
        end
    end

    assign trace_count_o = tcount;
    assign trace_pc_o    = rd_pc;
    assign trace_instr_o = rd_instr;
`else
    logic unused_trace;
    assign unused_trace  = ^{pc_i, trace_rd_idx_i};
    assign trace_count_o = '0;
    assign trace_pc_o    = '0;
    assign trace_instr_o = '0;
`endif

endmodule

// File: tb/tb_core_run_monitor.sv
// Directed bench for core_run_monitor: four instances cover ECALL drain, EBREAK with no drain, watchdog, and trace wrap / saturation / mid-drain reset.
// Trace expectations collapse to zero when MON_TRACE_EN is not defined.
module tb_core_run_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

`ifdef MON_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // a: defaults, b: DRAIN_CYCLES=0, c: TIMEOUT=50, d: depth 4 / drain 4 / 3-bit counters / no watchdog
    logic        rst_a, vld_a, rst_b, vld_b, rst_c, vld_c, rst_d, vld_d;
    logic [31:0] pc_a, ins_a, pc_b, ins_b, pc_c, ins_c, pc_d, ins_d;
    logic [3:0]  idx_a, idx_b, idx_c;
    logic [1:0]  idx_d;
    logic        halt_a, halt_b, halt_c, halt_d;
    logic [1:0]  cause_a, cause_b, cause_c, cause_d;
    logic [31:0] cyc_a, icnt_a, cyc_b, icnt_b, cyc_c, icnt_c;
    logic [2:0]  cyc_d, icnt_d;
    logic [4:0]  tcnt_a, tcnt_b, tcnt_c;
    logic [2:0]  tcnt_d;
    logic [31:0] tpc_a, tins_a, tpc_b, tins_b, tpc_c, tins_c, tpc_d, tins_d;

    core_run_monitor u_a (
        .clk(clk), .reset(rst_a), .valid_i(vld_a), .pc_i(pc_a), .instr_i(ins_a),
        .trace_rd_idx_i(idx_a), .halt_o(halt_a), .halt_cause_o(cause_a),
        .cycle_cnt_o(cyc_a), .instr_cnt_o(icnt_a), .trace_count_o(tcnt_a),
        .trace_pc_o(tpc_a), .trace_instr_o(tins_a)
    );

    core_run_monitor #(.DRAIN_CYCLES(0)) u_b (
        .clk(clk), .reset(rst_b), .valid_i(vld_b), .pc_i(pc_b), .instr_i(ins_b),
        .trace_rd_idx_i(idx_b), .halt_o(halt_b), .halt_cause_o(cause_b),
        .cycle_cnt_o(cyc_b), .instr_cnt_o(icnt_b), .trace_count_o(tcnt_b),
        .trace_pc_o(tpc_b), .trace_instr_o(tins_b)
    );

    core_run_monitor #(.TIMEOUT(50)) u_c (
        .clk(clk), .reset(rst_c), .valid_i(vld_c), .pc_i(pc_c), .instr_i(ins_c),
        .trace_rd_idx_i(idx_c), .halt_o(halt_c), .halt_cause_o(cause_c),
        .cycle_cnt_o(cyc_c), .instr_cnt_o(icnt_c), .trace_count_o(tcnt_c),
        .trace_pc_o(tpc_c), .trace_instr_o(tins_c)
    );

    core_run_monitor #(.CNT_W(3), .TRACE_DEPTH(4), .TIMEOUT(0), .DRAIN_CYCLES(4)) u_d (
        .clk(clk), .reset(rst_d), .valid_i(vld_d), .pc_i(pc_d), .instr_i(ins_d),
        .trace_rd_idx_i(idx_d), .halt_o(halt_d), .halt_cause_o(cause_d),
        .cycle_cnt_o(cyc_d), .instr_cnt_o(icnt_d), .trace_count_o(tcnt_d),
        .trace_pc_o(tpc_d), .trace_instr_o(tins_d)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1; rst_d = 1;
        vld_a = 0; vld_b = 0; vld_c = 0; vld_d = 0;
        pc_a = 0; pc_b = 0; pc_c = 0; pc_d = 0;
        ins_a = 0; ins_b = 0; ins_c = 0; ins_d = 0;
        idx_a = 0; idx_b = 0; idx_c = 0; idx_d = 0;
        step();
        step();

        // Reset values
        check_vec("rst_halt",  64'(halt_a),  64'd0);
        check_vec("rst_cause", 64'(cause_a), 64'd0);
        check_vec("rst_cyc",   64'(cyc_a),   64'd0);
        check_vec("rst_icnt",  64'(icnt_a),  64'd0);
        check_vec("rst_tcnt",  64'(tcnt_a),  64'd0);
        check_vec("rst_tpc",   64'(tpc_a),   64'd0);
        check_vec("rst_tins",  64'(tins_a),  64'd0);

        // ECALL with DRAIN_CYCLES=1
        rst_a = 0;
        for (int i = 0; i < 5; i++) begin
            vld_a = 1; pc_a = 32'(i * 4); ins_a = NOP;
            step();
        end
        check_vec("a_pre_halt", 64'(halt_a), 64'd0);
        pc_a = 32'h14; ins_a = ECALL;
        step();
        check_vec("a_drain_halt",  64'(halt_a),  64'd0);
        check_vec("a_drain_cause", 64'(cause_a), 64'd1);
        pc_a = 32'h18; ins_a = NOP;
        step();
        vld_a = 0;
        check_vec("a_halt",  64'(halt_a),  64'd1);
        check_vec("a_cause", 64'(cause_a), 64'd1);
        check_vec("a_icnt",  64'(icnt_a),  64'd6);
        check_vec("a_cyc",   64'(cyc_a),   64'd7);
        idx_a = 0;
        step();
        check_vec("a_tpc0",  64'(tpc_a),  TR ? 64'h14 : 64'h0);
        check_vec("a_tins0", 64'(tins_a), TR ? 64'h73 : 64'h0);
        check_vec("a_tcnt",  64'(tcnt_a), TR ? 64'd6 : 64'd0);
        idx_a = 1;
        step();
        check_vec("a_tpc1",  64'(tpc_a),  TR ? 64'h10 : 64'h0);
        check_vec("a_tins1", 64'(tins_a), TR ? 64'h13 : 64'h0);
        check_vec("a_cyc_frozen", 64'(cyc_a), 64'd7);

        // EBREAK with DRAIN_CYCLES=0
        rst_b = 0;
        vld_b = 1; pc_b = 0; ins_b = NOP; step();
        pc_b = 4; step();
        check_vec("b_pre_halt", 64'(halt_b), 64'd0);
        pc_b = 8; ins_b = EBREAK; step();
        check_vec("b_halt",  64'(halt_b),  64'd1);
        check_vec("b_cause", 64'(cause_b), 64'd2);
        check_vec("b_icnt",  64'(icnt_b),  64'd3);
        ins_b = NOP;
        for (int i = 0; i < 3; i++) begin
            vld_b = 1; step();
            vld_b = 0; step();
        end
        check_vec("b_icnt_frozen", 64'(icnt_b), 64'd3);
        check_vec("b_cyc_frozen",  64'(cyc_b),  64'd3);
        check_vec("b_halt_hold",   64'(halt_b), 64'd1);

        // Watchdog, TIMEOUT=50
        rst_c = 0;
        repeat (49) step();
        check_vec("c_cyc49",   64'(cyc_c),   64'd49);
        check_vec("c_cause49", 64'(cause_c), 64'd0);
        step();
        check_vec("c_cause_to", 64'(cause_c), 64'd3);
        check_vec("c_halt50",   64'(halt_c),  64'd0);
        step();
        check_vec("c_halt51", 64'(halt_c), 64'd1);
        check_vec("c_cyc51",  64'(cyc_c),  64'd51);
        repeat (5) step();
        check_vec("c_cyc_frozen", 64'(cyc_c),   64'd51);
        check_vec("c_cause_hold", 64'(cause_c), 64'd3);

        // ECALL on the same cycle the watchdog expires
        rst_c = 1; step();
        check_vec("c_rst_halt",  64'(halt_c),  64'd0);
        check_vec("c_rst_cause", 64'(cause_c), 64'd0);
        check_vec("c_rst_cyc",   64'(cyc_c),   64'd0);
        rst_c = 0;
        repeat (49) step();
        vld_c = 1; pc_c = 32'hC4; ins_c = ECALL; step();
        vld_c = 0;
        check_vec("c_tie_cause", 64'(cause_c), 64'd1);
        check_vec("c_tie_icnt",  64'(icnt_c),  64'd1);
        step();
        check_vec("c_tie_halt",  64'(halt_c),  64'd1);

        // Trace wrap with depth 4, counter saturation at 7
        rst_d = 0;
        for (int i = 0; i < 6; i++) begin
            vld_d = 1; pc_d = 32'(i * 4); ins_d = NOP;
            step();
        end
        vld_d = 0;
        check_vec("d_tcnt", 64'(tcnt_d), TR ? 64'd4 : 64'd0);
        check_vec("d_icnt", 64'(icnt_d), 64'd6);
        for (int k = 0; k < 4; k++) begin
            idx_d = 2'(k);
            step();
            check_vec($sformatf("d_tpc%0d", k), 64'(tpc_d), TR ? 64'(20 - 4 * k) : 64'd0);
        end
        check_vec("d_cyc_sat", 64'(cyc_d), 64'd7);
        vld_d = 1; pc_d = 24; step();
        pc_d = 28; step();
        vld_d = 0;
        check_vec("d_icnt_sat", 64'(icnt_d), 64'd7);
        idx_d = 0; step();
        check_vec("d_tpc_new", 64'(tpc_d), TR ? 64'd28 : 64'd0);

        // Reset in the middle of a 4-cycle drain
        vld_d = 1; pc_d = 32; ins_d = ECALL; step();
        vld_d = 0; ins_d = NOP;
        check_vec("d_drain_cause", 64'(cause_d), 64'd1);
        step(); check_vec("d_drain_halt1", 64'(halt_d), 64'd0);
        step(); check_vec("d_drain_halt2", 64'(halt_d), 64'd0);
        rst_d = 1; step();
        check_vec("d_rst_halt",  64'(halt_d),  64'd0);
        check_vec("d_rst_cause", 64'(cause_d), 64'd0);
        check_vec("d_rst_cyc",   64'(cyc_d),   64'd0);
        check_vec("d_rst_icnt",  64'(icnt_d),  64'd0);
        check_vec("d_rst_tcnt",  64'(tcnt_d),  64'd0);
        check_vec("d_rst_tpc",   64'(tpc_d),   64'd0);
        check_vec("d_rst_tins",  64'(tins_d),  64'd0);
        rst_d = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_vec($sformatf("d_post_halt%0d", i), 64'(halt_d), 64'd0);
        end
        check_vec("d_post_cyc",   64'(cyc_d),   64'd6);
        check_vec("d_post_cause", 64'(cause_d), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
